multi_blinker: RTL and testbench



---
 rtl/blinker_pkg.sv | 35 +++
 rtl/multi_blinker_channel.sv | 173 +++++++++++++++++
 rtl/multi_blinker.sv | 70 +++++++
 tb/tb_multi_blinker.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/blinker_pkg.sv
// blinker_pkg: shared types for the multi-channel LED blinker.
//   pattern_t     - one blink pattern (on ticks, off ticks, blink count)
//   ch_state_t    - per-channel FSM state
//   pattern_lookup- fixed 4-entry pattern table indexed by pat_sel
package blinker_pkg;

  localparam int PAT_SEL_W = 2;
  localparam int PAT_PH_W  = 8;
  localparam int PAT_CNT_W = 4;

  typedef struct packed {
    logic [PAT_PH_W-1:0]  on_t;
    logic [PAT_PH_W-1:0]  off_t;
    logic [PAT_CNT_W-1:0] count;
  } pattern_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } ch_state_t;

  // 0 ERROR, 1 OK, 2 ACK, 3 IDLE_HINT (count 0: completes without lighting)
  function automatic pattern_t pattern_lookup(input logic [PAT_SEL_W-1:0] sel);
    pattern_t p;
    case (sel)
      2'd0:    p = '{on_t: 8'd5,  off_t: 8'd10, count: 4'd3};
      2'd1:    p = '{on_t: 8'd2,  off_t: 8'd2,  count: 4'd5};
      2'd2:    p = '{on_t: 8'd1,  off_t: 8'd1,  count: 4'd1};
      default: p = '{on_t: 8'd10, off_t: 8'd10, count: 4'd0};
    endcase
    return p;
  endfunction

endpackage

// File: rtl/multi_blinker_channel.sv
// blink_channel: one LED channel; plays a table pattern counted in prescaler ticks.
// Ports:
//   hwclk, rst       clock, async active-high reset
//   tick             shared one-cycle timebase pulse
//   start, pat_sel   start request and pattern index (sampled in IDLE only)
//   abort            (only with BLINKER_ABORT_EN) stop the running pattern
//   led, busy, done  registered outputs; done is a one-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for start, led off
// ON    | led lit, counting on ticks
// OFF   | led dark, counting off ticks; last OFF phase returns to IDLE
module blink_channel
  import blinker_pkg::*;
#(
  parameter int PH_W  = 8,
  parameter int CNT_W = 4
) (
  input  logic                 hwclk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 start,
  input  logic [PAT_SEL_W-1:0] pat_sel,
`ifdef BLINKER_ABORT_EN
  input  logic                 abort,
`endif
  output logic                 led,
  output logic                 busy,
  output logic                 done
);

  ch_state_t         state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [PH_W-1:0]   on_lim_q, on_lim_d;
  logic [PH_W-1:0]   off_lim_q, off_lim_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic              led_q, led_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  pattern_t          pat;
  logic [PH_W-1:0]   ph_inc;
  logic              abort_req;

`ifdef BLINKER_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign pat    = pattern_lookup(pat_sel);
  assign ph_inc = phase_q + PH_W'(1);

  // A zero-length phase would never be reached by the incrementing counter,
  // so it is stretched to one tick.
  function automatic logic [PH_W-1:0] phase_limit(input logic [PAT_PH_W-1:0] t);
    logic [PH_W-1:0] v;
    v = PH_W'(t);
    if (v == '0) v = PH_W'(1);
    return v;
  endfunction

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    on_lim_d  = on_lim_q;
    off_lim_d = off_lim_q;
    rem_d     = rem_q;
    led_d     = led_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        led_d  = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          if (pat.count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d   = ST_ON;
            led_d     = 1'b1;
            busy_d    = 1'b1;
            phase_d   = '0;
            rem_d     = CNT_W'(pat.count);
            on_lim_d  = phase_limit(pat.on_t);
            off_lim_d = phase_limit(pat.off_t);
          end
        end
      end

      ST_ON: begin
        if (abort_req) begin
          state_d = ST_IDLE;
          led_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          phase_d = '0;
          rem_d   = '0;
        end else if (tick) begin
          if (ph_inc == on_lim_q) begin
            state_d = ST_OFF;
            led_d   = 1'b0;
            phase_d = '0;
          end else begin
            phase_d = ph_inc;
          end
        end
      end

      ST_OFF: begin
        if (abort_req) begin
          state_d = ST_IDLE;
          led_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          phase_d = '0;
          rem_d   = '0;
        end else if (tick) begin
          if (ph_inc == off_lim_q) begin
            phase_d = '0;
            rem_d   = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d = ST_ON;
              led_d   = 1'b1;
            end
          end else begin
            phase_d = ph_inc;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        led_d   = 1'b0;
        busy_d  = 1'b0;
        phase_d = '0;
        rem_d   = '0;
      end
    endcase
  end

  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      on_lim_q  <= '0;
      off_lim_q <= '0;
      rem_q     <= '0;
      led_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      on_lim_q  <= on_lim_d;
      off_lim_q <= off_lim_d;
      rem_q     <= rem_d;
      led_q     <= led_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign led  = led_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: rtl/multi_blinker.sv
// multi_blinker: N_CH independent LED blink channels sharing one tick prescaler.
// Optional feature macro: BLINKER_ABORT_EN adds the per-channel abort input.
// Ports:
//   hwclk    system clock
//   rst      async active-high reset
//   start    per-channel start request
//   pat_sel  per-channel 2-bit pattern index (channel i at [2i+1:2i])
//   abort    per-channel abort (BLINKER_ABORT_EN only)
//   led      registered LED drive, 1 = lit
//   busy     channel is playing a pattern
//   done     one-cycle completion pulse
module multi_blinker
  import blinker_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int TICK_DIV = 1200000,
  parameter int PH_W     = 8,
  parameter int CNT_W    = 4
) (
  input  logic                        hwclk,
  input  logic                        rst,
  input  logic [N_CH-1:0]             start,
  input  logic [PAT_SEL_W*N_CH-1:0]   pat_sel,
`ifdef BLINKER_ABORT_EN
  input  logic [N_CH-1:0]             abort,
`endif
  output logic [N_CH-1:0]             led,
  output logic [N_CH-1:0]             busy,
  output logic [N_CH-1:0]             done
);

  localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PS_W-1:0] presc_q, presc_d;
  logic            tick;

  // Free-running; start never realigns it, so the first ON phase of a
  // pattern is shortened by whatever prescaler phase it started in.
  assign tick = (presc_q == PS_W'(TICK_DIV - 1));

  always_comb begin
    presc_d = presc_q + PS_W'(1);
    if (tick) presc_d = '0;
  end

  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) presc_q <= '0;
    else     presc_q <= presc_d;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    blink_channel #(
      .PH_W  (PH_W),
      .CNT_W (CNT_W)
    ) u_ch (
      .hwclk   (hwclk),
      .rst     (rst),
      .tick    (tick),
      .start   (start[i]),
      .pat_sel (pat_sel[PAT_SEL_W*i +: PAT_SEL_W]),
`ifdef BLINKER_ABORT_EN
      .abort   (abort[i]),
`endif
      .led     (led[i]),
      .busy    (busy[i]),
      .done    (done[i])
    );
  end

endmodule

// File: tb/tb_multi_blinker.sv
module tb_multi_blinker;

  localparam int N_CH = 4;
  localparam int TDIV = 4;
  localparam int ON_T  [4] = '{5, 2, 1, 10};
  localparam int OFF_T [4] = '{10, 2, 1, 10};
  localparam int CNT   [4] = '{3, 5, 1, 0};

  logic              hwclk;
  logic              rst;
  logic [N_CH-1:0]   start;
  logic [2*N_CH-1:0] pat_sel;
`ifdef BLINKER_ABORT_EN
  logic [N_CH-1:0]   abort;
`endif
  logic [N_CH-1:0]   led, busy, done;

  multi_blinker #(.N_CH(N_CH), .TICK_DIV(TDIV), .PH_W(8), .CNT_W(4)) dut (
    .hwclk   (hwclk),
    .rst     (rst),
    .start   (start),
    .pat_sel (pat_sel),
`ifdef BLINKER_ABORT_EN
    .abort   (abort),
`endif
    .led     (led),
    .busy    (busy),
    .done    (done)
  );

  initial hwclk = 1'b0;
  always #5 hwclk = ~hwclk;

  // Expected output snapshot of one channel right after edge 'at'.
  typedef struct {
    int   at;
    logic led;
    logic busy;
    logic done;
  } snap_t;

  snap_t exp_q [N_CH][$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    edge_n;

  // Edges counted from reset release; tick fires at edges that are multiples of TDIV.
  always @(posedge hwclk or posedge rst) begin
    if (rst) edge_n <= 0;
    else     edge_n <= edge_n + 1;
  end

  function automatic void push_exp(input int ch, input int at, input logic l,
                                   input logic b, input logic d);
    snap_t s;
    s.at = at; s.led = l; s.busy = b; s.done = d;
    if (exp_q[ch].size() > 0 && exp_q[ch][exp_q[ch].size()-1].at == at)
      exp_q[ch][exp_q[ch].size()-1] = s;
    else
      exp_q[ch].push_back(s);
  endfunction

  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  // Hand-derived schedule: start sampled at edge k, first tick at the next
  // multiple of TDIV, every later phase a whole number of TDIV cycles.
  function automatic void schedule(input int ch, input int p, input int k);
    int t, fall, endp;
    if (CNT[p] == 0) begin
      push_exp(ch, k, 1'b0, 1'b0, 1'b1);
      push_exp(ch, k + 1, 1'b0, 1'b0, 1'b0);
      return;
    end
    push_exp(ch, k, 1'b1, 1'b1, 1'b0);
    t    = (k / TDIV + 1) * TDIV;
    fall = t + (max1(ON_T[p]) - 1) * TDIV;
    for (int b = 1; b <= CNT[p]; b++) begin
      push_exp(ch, fall, 1'b0, 1'b1, 1'b0);
      endp = fall + max1(OFF_T[p]) * TDIV;
      if (b == CNT[p]) begin
        push_exp(ch, endp, 1'b0, 1'b0, 1'b1);
        push_exp(ch, endp + 1, 1'b0, 1'b0, 1'b0);
      end else begin
        push_exp(ch, endp, 1'b1, 1'b1, 1'b0);
        fall = endp + max1(ON_T[p]) * TDIV;
      end
    end
  endfunction

  // Monitor: any change on a channel's outputs must match the next queued snapshot.
  logic [N_CH-1:0] prev_led, prev_busy, prev_done;
  always @(negedge hwclk) begin
    if (rst) begin
      prev_led  = '0;
      prev_busy = '0;
      prev_done = '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (led[c] !== prev_led[c] || busy[c] !== prev_busy[c] || done[c] !== prev_done[c]) begin
          n_checks++;
          if (exp_q[c].size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_change ch%0d edge %0d: got led=%b busy=%b done=%b, expected no change",
                     c, edge_n, led[c], busy[c], done[c]);
          end else begin
            snap_t s;
            s = exp_q[c].pop_front();
            if (s.at != edge_n || s.led !== led[c] || s.busy !== busy[c] || s.done !== done[c]) begin
              n_fail++;
              $display("FAIL event ch%0d: got edge %0d led=%b busy=%b done=%b, expected edge %0d led=%b busy=%b done=%b",
                       c, edge_n, led[c], busy[c], done[c], s.at, s.led, s.busy, s.done);
            end
          end
        end
      end
      prev_led  = led;
      prev_busy = busy;
      prev_done = done;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // Call at a negedge: requests are sampled at the next posedge.
  task automatic start_vec(input logic [N_CH-1:0] mask, input logic [2*N_CH-1:0] pats,
                           input bit sched);
    for (int c = 0; c < N_CH; c++) begin
      if (mask[c]) begin
        start[c] = 1'b1;
        pat_sel[2*c +: 2] = pats[2*c +: 2];
        if (sched) schedule(c, int'(pats[2*c +: 2]), edge_n + 1);
      end
    end
    @(negedge hwclk);
    start = '0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    int left;
    n = 0;
    left = 1;
    while (left != 0 && n < budget) begin
      @(negedge hwclk);
      n++;
      left = 0;
      for (int c = 0; c < N_CH; c++) left += exp_q[c].size();
    end
    chk({name, "_drain_timeout"}, 32'(left), 32'd0);
    repeat (5) @(negedge hwclk);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    start   = '0;
    pat_sel = '0;
`ifdef BLINKER_ABORT_EN
    abort   = '0;
`endif
    #23;
    chk("reset_led",  32'(led),  32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    @(negedge hwclk);
    rst = 1'b0;

    // 1: idle for 100 cycles
    repeat (100) @(negedge hwclk);
    chk("idle_led",  32'(led),  32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);

    // 2: OK pattern on channel 0
    start_vec(4'b0001, 8'h01, 1'b1);
    chk("ok_busy_after_start", 32'(busy[0]), 32'd1);
    chk("ok_led_after_start",  32'(led[0]),  32'd1);
    wait_drain("ok", 400);

    // 3: start while busy is ignored
    start_vec(4'b0010, 8'h08, 1'b1);
    chk("ack_busy", 32'(busy[1]), 32'd1);
    start_vec(4'b0010, 8'h00, 1'b0);
    wait_drain("ack_ignore", 200);

    // 4: count-0 pattern, then a start in its done cycle
    start_vec(4'b1000, 8'hC0, 1'b1);
    chk("hint_busy", 32'(busy[3]), 32'd0);
    chk("hint_done", 32'(done[3]), 32'd1);
    start_vec(4'b1000, 8'h80, 1'b1);
    wait_drain("hint_restart", 200);

    // 5: simultaneous starts, patterns 0..3
    start_vec(4'b1111, 8'hE4, 1'b1);
    chk("multi_busy", 32'(busy), 32'h7);
    wait_drain("multi", 1000);

    // 6: async reset mid-pattern 0
    start_vec(4'b0001, 8'h00, 1'b1);
    repeat (30) @(negedge hwclk);
    chk("pre_rst_busy", 32'(busy[0]), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_led",  32'(led),  32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    for (int c = 0; c < N_CH; c++) exp_q[c].delete();
    repeat (2) @(negedge hwclk);
    rst = 1'b0;
    repeat (250) @(negedge hwclk);
    chk("post_rst_busy", 32'(busy), 32'd0);

`ifdef BLINKER_ABORT_EN
    begin
      int n;
      start_vec(4'b0100, 8'h00, 1'b1);
      n = 0;
      while (!(busy[2] && !led[2]) && n < 200) begin
        @(negedge hwclk);
        n++;
      end
      chk("abort_reach_off_timeout", 32'(n < 200), 32'd1);
      repeat (2) @(negedge hwclk);
      exp_q[2].delete();
      push_exp(2, edge_n + 1, 1'b0, 1'b0, 1'b1);
      push_exp(2, edge_n + 2, 1'b0, 1'b0, 1'b0);
      abort[2] = 1'b1;
      @(negedge hwclk);
      abort[2] = 1'b0;
      wait_drain("abort", 50);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
